// File: rtl/rfphoenix_thread_sched.sv
// rfphoenix_thread_sched: round-robin instruction-fetch scheduler for the
// barrel-threaded rfPhoenix front end. Each thread runs a small RUN / MISS /
// HOLD / SLEEP state machine. Every cycle one eligible thread is granted the
// fetch slot, scanning upward from the thread after the last one granted.
module rfphoenix_thread_sched #(
  parameter int                  NTHREADS       = 4,
  parameter int                  MISS_HOLD      = 2,
  parameter logic [NTHREADS-1:0] RESET_RUN_MASK = 'b0001
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        stall_i,
  input  logic [NTHREADS-1:0]         sleep_i,
  input  logic [NTHREADS-1:0]         wake_i,
  input  logic                        miss_i,
  input  logic [$clog2(NTHREADS)-1:0] miss_tid_i,
  input  logic                        fill_i,
  input  logic [$clog2(NTHREADS)-1:0] fill_tid_i,
  output logic [$clog2(NTHREADS)-1:0] thread_o,
  output logic                        thread_v_o,
  output logic [NTHREADS-1:0]         grant_o,
  output logic [NTHREADS-1:0]         run_mask_o,
  output logic [NTHREADS-1:0]         miss_mask_o,
  output logic [NTHREADS-1:0]         sleep_mask_o
);

  localparam int             TW        = $clog2(NTHREADS);
  localparam int             CW        = 5;
  localparam logic [CW-1:0]  HOLD_INIT = CW'(MISS_HOLD);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_SLEEP = 2'd3
  } tstate_t;

  tstate_t             state_q [NTHREADS];
  tstate_t             state_n [NTHREADS];
  logic [CW-1:0]       cnt_q   [NTHREADS];
  logic [CW-1:0]       cnt_n   [NTHREADS];

  logic [NTHREADS-1:0] miss_hit;
  logic [NTHREADS-1:0] fill_hit;
  logic [NTHREADS-1:0] elig;
  logic [NTHREADS-1:0] run_n;
  logic [NTHREADS-1:0] miss_n;
  logic [NTHREADS-1:0] sleep_n;

  logic [TW-1:0]       ptr_q;
  logic [TW-1:0]       sel;
  logic                found;

  logic [TW-1:0]       thread_q;
  logic                thread_v_q;
  logic [NTHREADS-1:0] grant_q;
  logic [NTHREADS-1:0] run_q;
  logic [NTHREADS-1:0] miss_q;
  logic [NTHREADS-1:0] sleep_q;

  // Decode the miss/fill thread ids into per-thread strobes.
  always_comb begin
    miss_hit = '0;
    fill_hit = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      miss_hit[t] = miss_i && (miss_tid_i == TW'(t));
      fill_hit[t] = fill_i && (fill_tid_i == TW'(t));
    end
  end

  // Per-thread next state: sleep beats everything, then wake, miss, fill, hold-off.
  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      state_n[t] = state_q[t];
      cnt_n[t]   = cnt_q[t];
      if (sleep_i[t]) begin
        // Sleeping abandons any in-flight miss, so a later fill finds no MISS.
        state_n[t] = ST_SLEEP;
        cnt_n[t]   = '0;
      end else begin
        case (state_q[t])
          ST_SLEEP: begin
            if (wake_i[t]) state_n[t] = ST_RUN;
          end
          ST_RUN: begin
            if (miss_hit[t]) state_n[t] = ST_MISS;
          end
          ST_MISS: begin
            // A miss in the same cycle as the fill means a new line is outstanding.
            if (!miss_hit[t] && fill_hit[t]) begin
              if (MISS_HOLD == 0) begin
                state_n[t] = ST_RUN;
              end else begin
                state_n[t] = ST_HOLD;
                cnt_n[t]   = HOLD_INIT;
              end
            end
          end
          ST_HOLD: begin
            if (miss_hit[t]) begin
              state_n[t] = ST_MISS;
              cnt_n[t]   = '0;
            end else if (cnt_q[t] <= CW'(1)) begin
              state_n[t] = ST_RUN;
              cnt_n[t]   = '0;
            end else begin
              cnt_n[t] = cnt_q[t] - CW'(1);
            end
          end
          default: begin
            state_n[t] = ST_SLEEP;
            cnt_n[t]   = '0;
          end
        endcase
      end
    end
  end

  // Next-cycle status masks, registered alongside the state.
  always_comb begin
    run_n   = '0;
    miss_n  = '0;
    sleep_n = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      run_n[t]   = (state_n[t] == ST_RUN);
      miss_n[t]  = (state_n[t] == ST_MISS);
      sleep_n[t] = (state_n[t] == ST_SLEEP);
    end
  end

  // Eligibility: running now, with same-cycle sleep and miss bypassed in.
  always_comb begin
    elig = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      elig[t] = (state_q[t] == ST_RUN) && !sleep_i[t] && !miss_hit[t];
    end
  end

  // Round-robin pick: first eligible thread after the pointer, with wrap.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = ptr_q;
    for (int k = 1; k <= NTHREADS; k++) begin
      idx = (int'(ptr_q) + k) % NTHREADS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = TW'(idx);
      end
    end
  end

  // Thread state registers; masks are kept registered to match the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= RESET_RUN_MASK[t] ? ST_RUN : ST_SLEEP;
        cnt_q[t]   <= '0;
      end
      run_q   <= RESET_RUN_MASK;
      miss_q  <= '0;
      sleep_q <= ~RESET_RUN_MASK;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        state_q[t] <= state_n[t];
        cnt_q[t]   <= cnt_n[t];
      end
      run_q   <= run_n;
      miss_q  <= miss_n;
      sleep_q <= sleep_n;
    end
  end

  // Grant registers: a stall freezes the grant and pointer, an empty scan drops valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= TW'(NTHREADS - 1);
      thread_q   <= '0;
      thread_v_q <= 1'b0;
      grant_q    <= '0;
    end else if (!stall_i) begin
      if (found) begin
        ptr_q      <= sel;
        thread_q   <= sel;
        thread_v_q <= 1'b1;
        grant_q    <= NTHREADS'(1) << sel;
      end else begin
        thread_v_q <= 1'b0;
        grant_q    <= '0;
      end
    end
  end

  assign thread_o     = thread_q;
  assign thread_v_o   = thread_v_q;
  assign grant_o      = grant_q;
  assign run_mask_o   = run_q;
  assign miss_mask_o  = miss_q;
  assign sleep_mask_o = sleep_q;

endmodule
